fpu_div_post_norm: RTL and testbench

//  Downstream stage of the 6-cycle pipelined 27/27-bit mantissa divider in the OR1200 FPU.

---
 rtl/fpu_div_post_norm.sv | 166 ++++++++++++++++
 tb/tb_fpu_div_post_norm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fpu_div_post_norm.sv
// Post-normalisation stage of the pipelined mantissa divider: delays the op side-band to meet the
// quotient, then normalises, rounds and packs an IEEE-754 single with exception flags.
module fpu_div_post_norm #(
  parameter int DIV_LAT = 6,
  parameter int EXP_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [1:0]       in_rmode,
  input  logic             in_nan,
  input  logic             in_inf,
  input  logic             in_zero,
  input  logic [26:0]      div_quotient,
  input  logic [26:0]      div_remainder,
  input  logic             div_by_0,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic             out_inexact,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_div_zero
);
  localparam int STAGES = DIV_LAT + 2;
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'(255);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [1:0]       rmode;
    logic             nan;
    logic             inf;
    logic             zero;
  } side_t;

  // vld_pipe[i] is the valid bit of pipeline stage i; stage DIV_LAT meets the divider output
  logic [STAGES:1] vld_pipe;
  side_t           sb_pipe [1:DIV_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  always_ff @(posedge clk) sb_pipe[1] <= '{in_sign, in_exp, in_rmode, in_nan, in_inf, in_zero};

  for (genvar i = 2; i <= DIV_LAT; i++) begin : g_sb
    always_ff @(posedge clk) sb_pipe[i] <= sb_pipe[i-1];
  end

  // ---- stage N: normalise the Q1.26 quotient to a 24-bit mantissa plus guard/round/sticky
  side_t            n_sb;
  logic [EXP_W:0]   n_exp, n_exp_d;
  logic [23:0]      n_mant, n_mant_d;
  logic             n_g, n_r, n_s, n_dz;
  logic             n_g_d, n_r_d, n_s_d;
  logic             rem_nz;
  side_t            sb_last;

  assign sb_last = sb_pipe[DIV_LAT];
  assign rem_nz  = |div_remainder;

  always_comb begin
    n_mant_d = div_quotient[25:2];
    n_g_d    = div_quotient[1];
    n_r_d    = div_quotient[0];
    n_s_d    = rem_nz;
    n_exp_d  = {sb_last.exp[EXP_W-1], sb_last.exp} - (EXP_W+1)'(1);
    if (div_quotient[26]) begin
      n_mant_d = div_quotient[26:3];
      n_g_d    = div_quotient[2];
      n_r_d    = div_quotient[1];
      n_s_d    = div_quotient[0] | rem_nz;
      n_exp_d  = {sb_last.exp[EXP_W-1], sb_last.exp};
    end
  end

  always_ff @(posedge clk) begin
    if (vld_pipe[DIV_LAT]) begin
      n_sb   <= sb_last;
      n_exp  <= n_exp_d;
      n_mant <= n_mant_d;
      n_g    <= n_g_d;
      n_r    <= n_r_d;
      n_s    <= n_s_d;
      n_dz   <= div_by_0;
    end
  end

  // ---- stage R: round, detect range errors, apply special cases
  logic                    rnd_up, lost, ovf, unf, ovf_to_inf;
  logic [24:0]             mant_inc;
  logic signed [EXP_W+1:0] e_r;
  logic [31:0]             res_d;
  logic                    inex_d, ovf_d, unf_d, dz_d;

  always_comb begin
    lost = n_g | n_r | n_s;
    unique case (n_sb.rmode)
      2'b00:   rnd_up = n_g & (n_r | n_s | n_mant[0]);
      2'b01:   rnd_up = 1'b0;
      2'b10:   rnd_up = ~n_sb.sign & lost;
      default: rnd_up = n_sb.sign & lost;
    endcase
    mant_inc = {1'b0, n_mant} + {24'd0, rnd_up};
    // carry-out leaves mant_inc[23:0] all zero apart from the hidden bit handling below
    e_r      = $signed({n_exp[EXP_W], n_exp}) + $signed({{(EXP_W+1){1'b0}}, mant_inc[24]});
    ovf      = e_r >= EMAX;
    unf      = e_r <= 0;
    ovf_to_inf = (n_sb.rmode == 2'b00) || (n_sb.rmode == 2'b10 && !n_sb.sign) ||
                 (n_sb.rmode == 2'b11 && n_sb.sign);

    res_d  = {n_sb.sign, e_r[7:0], (mant_inc[24] ? 23'd0 : mant_inc[22:0])};
    inex_d = lost;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    dz_d   = 1'b0;
    if (ovf) begin
      res_d  = ovf_to_inf ? {n_sb.sign, 31'h7F800000} : {n_sb.sign, 31'h7F7FFFFF};
      ovf_d  = 1'b1;
      inex_d = 1'b1;
    end else if (unf) begin
      res_d  = {n_sb.sign, 31'd0};
      unf_d  = 1'b1;
      inex_d = 1'b1;
    end

    if (n_sb.nan) begin
      res_d  = 32'h7FC00000;
      inex_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else if (n_dz || n_sb.inf) begin
      res_d  = {n_sb.sign, 31'h7F800000};
      inex_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      dz_d   = n_dz;
    end else if (n_sb.zero) begin
      res_d  = {n_sb.sign, 31'd0};
      inex_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result    <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_div_zero  <= 1'b0;
    end else if (vld_pipe[DIV_LAT+1]) begin
      out_result    <= res_d;
      out_inexact   <= inex_d;
      out_overflow  <= ovf_d;
      out_underflow <= unf_d;
      out_div_zero  <= dz_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fpu_div_post_norm.sv
// Scoreboard bench for fpu_div_post_norm: directed ops with hand-computed results, a behavioural
// 6-deep divider delay feeding the quotient, and a monitor checking value and latency of each output.
module tb_fpu_div_post_norm;
  localparam int DIV_LAT = 6;
  localparam int EXP_W   = 10;
  localparam int LAT     = DIV_LAT + 2;

  logic             clk, rst_n;
  logic             in_valid, in_sign, in_nan, in_inf, in_zero;
  logic [EXP_W-1:0] in_exp;
  logic [1:0]       in_rmode;
  logic [26:0]      div_quotient, div_remainder;
  logic             div_by_0;
  logic             out_valid, out_inexact, out_overflow, out_underflow, out_div_zero;
  logic [31:0]      out_result;

  fpu_div_post_norm #(.DIV_LAT(DIV_LAT), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sign(in_sign), .in_exp(in_exp),
    .in_rmode(in_rmode), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_by_0(div_by_0),
    .out_valid(out_valid), .out_result(out_result), .out_inexact(out_inexact),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_div_zero(out_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // divider stand-in: fixed DIV_LAT register delay, never reset
  typedef struct packed { logic [26:0] q; logic [26:0] rem; logic dz; } dv_t;
  dv_t dpipe [DIV_LAT];
  dv_t op_dv;
  always @(posedge clk) begin
    dpipe[0] <= op_dv;
    for (int i = 1; i < DIV_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_quotient  = dpipe[DIV_LAT-1].q;
  assign div_remainder = dpipe[DIV_LAT-1].rem;
  assign div_by_0      = dpipe[DIV_LAT-1].dz;

  typedef struct packed {
    logic sign; logic [EXP_W-1:0] exp; logic [1:0] rm; logic nan, inf, zero;
    logic [26:0] q, rem; logic dz; logic [35:0] expv;
  } vec_t;
  typedef struct { logic [35:0] v; int c; int id; } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   next_id = 0;

  function automatic vec_t mk(input logic s, input logic [EXP_W-1:0] e, input logic [1:0] rm,
                              input logic nan, input logic inf, input logic zero,
                              input logic [26:0] q, input logic [26:0] rem, input logic dz,
                              input logic [31:0] res, input logic [3:0] flags);
    vec_t v;
    v.sign = s; v.exp = e; v.rm = rm; v.nan = nan; v.inf = inf; v.zero = zero;
    v.q = q; v.rem = rem; v.dz = dz; v.expv = {res, flags};
    return v;
  endfunction

  task automatic issue(input vec_t v, input bit push);
    in_valid = 1'b1; in_sign = v.sign; in_exp = v.exp; in_rmode = v.rm;
    in_nan = v.nan; in_inf = v.inf; in_zero = v.zero;
    op_dv = '{v.q, v.rem, v.dz};
    if (push) sb_q.push_back('{v.expv, cyc, next_id});
    next_id++;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_rmode = 2'b00;
    in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0; op_dv = '0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({out_valid, out_result, out_inexact, out_overflow, out_underflow, out_div_zero} != '0) begin
      errors++;
      $display("FAIL %s: got valid=%b result=%h flags=%b%b%b%b, required all zero", name, out_valid,
               out_result, out_inexact, out_overflow, out_underflow, out_div_zero);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // monitor: pop and compare every presented result
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid: got result=%h, required no output", out_result);
      end else begin
        exp_t e;
        logic [35:0] got;
        e = sb_q.pop_front();
        got = {out_result, out_inexact, out_overflow, out_underflow, out_div_zero};
        checks += 2;
        if (got !== e.v) begin
          errors++;
          $display("FAIL op%0d value: got result=%h ixoud=%b, required result=%h ixoud=%b",
                   e.id, got[35:4], got[3:0], e.v[35:4], e.v[3:0]);
        end
        if (cyc - e.c != LAT) begin
          errors++;
          $display("FAIL op%0d latency: got %0d cycles, required %0d", e.id, cyc - e.c, LAT);
        end
      end
    end
  end

  initial begin
    // flags order: inexact, overflow, underflow, div_zero
    vecs.push_back(mk(0, 10'd128, 2'b00, 0,0,0, 27'h4000000, 27'd0, 0, 32'h40000000, 4'b0000));
    vecs.push_back(mk(0, 10'd127, 2'b00, 0,0,0, 27'h2AAAAAA, 27'd5, 0, 32'h3F2AAAAB, 4'b1000));
    vecs.push_back(mk(0, 10'd127, 2'b01, 0,0,0, 27'h2AAAAAA, 27'd5, 0, 32'h3F2AAAAA, 4'b1000));
    vecs.push_back(mk(1, 10'd127, 2'b10, 0,0,0, 27'h2AAAAAA, 27'd5, 0, 32'hBF2AAAAA, 4'b1000));
    vecs.push_back(mk(1, 10'd127, 2'b11, 0,0,0, 27'h2AAAAAA, 27'd5, 0, 32'hBF2AAAAB, 4'b1000));
    vecs.push_back(mk(0, 10'd127, 2'b00, 0,0,0, 27'h7FFFFFF, 27'd0, 0, 32'h40000000, 4'b1000));
    vecs.push_back(mk(0, 10'd254, 2'b00, 0,0,0, 27'h7FFFFFF, 27'd0, 0, 32'h7F800000, 4'b1100));
    vecs.push_back(mk(0, 10'd254, 2'b01, 0,0,0, 27'h7FFFFFF, 27'd0, 0, 32'h7F7FFFFF, 4'b1000));
    vecs.push_back(mk(1, 10'd255, 2'b10, 0,0,0, 27'h4000000, 27'd0, 0, 32'hFF7FFFFF, 4'b1100));
    vecs.push_back(mk(1, 10'd255, 2'b11, 0,0,0, 27'h4000000, 27'd0, 0, 32'hFF800000, 4'b1100));
    vecs.push_back(mk(1, 10'd1,   2'b00, 0,0,0, 27'h2000000, 27'd0, 0, 32'h80000000, 4'b1010));
    vecs.push_back(mk(0, 10'h3FB, 2'b00, 0,0,0, 27'h4000000, 27'd0, 0, 32'h00000000, 4'b1010));
    vecs.push_back(mk(0, 10'd127, 2'b00, 0,0,0, 27'h4000001, 27'd0, 0, 32'h3F800000, 4'b1000));
    vecs.push_back(mk(0, 10'd127, 2'b00, 1,0,0, 27'h4000000, 27'd0, 1, 32'h7FC00000, 4'b0000));
    vecs.push_back(mk(1, 10'd127, 2'b00, 0,0,0, 27'h4000000, 27'd0, 1, 32'hFF800000, 4'b0001));
    vecs.push_back(mk(0, 10'd127, 2'b00, 0,1,0, 27'h2AAAAAA, 27'd3, 0, 32'h7F800000, 4'b0000));
    vecs.push_back(mk(1, 10'd127, 2'b00, 0,0,1, 27'h2AAAAAA, 27'd3, 0, 32'h80000000, 4'b0000));

    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // directed vectors, issued back to back
    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i], 1'b1);
    end
    @(negedge clk);
    idle();
    drain(100);

    // reset asserted on the 4th of 8 consecutive ops; only ops after release may emerge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b0;
      if (i == 4) begin
        check_reset_outputs("midflight_reset");
        rst_n = 1'b1;
      end
      issue(mk(0, EXP_W'(120 + i), 2'b00, 0,0,0, 27'h4000000, 27'd0, 0,
               32'(120 + i) << 23, 4'b0000), i >= 4);
    end
    @(negedge clk);
    idle();
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
